// File: rtl/vend_pkg.sv
// Shared types and coin encoding for the vending transaction path.
// The coin encoding is the same as the one used by the 15-unit vending FSM.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CREDIT   = 2'd1,
      DISPENSE = 2'd2,
      CHANGE   = 2'd3
   } state_t;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;
   localparam logic [1:0] COIN_BAD  = 2'b11;

   localparam logic [3:0] CHANGE_UNIT = 4'd5;

   function automatic logic [3:0] coin_value(input logic [1:0] code);
      case (code)
         COIN_5:  coin_value = 4'd5;
         COIN_10: coin_value = 4'd10;
         default: coin_value = 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_down_timer.sv
// Loadable down-counter. expire is high while enabled and at the final count,
// so the edge that samples it is exactly `value` edges after the load.
module vend_down_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         enable,
   output logic         expire
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= {W{1'b0}};
      end else if (load) begin
         count <= value;
      end else if (enable && (count != {W{1'b0}})) begin
         count <= count - W'(1);
      end else begin
         count <= count;
      end
   end

   assign expire = enable && (count <= W'(1));

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: coin credit, select/cancel/timeout arbitration,
// dispense handshake and change paid out as paced 5-unit pulses.
module vend_txn_controller
   import vend_pkg::*;
#(
   parameter int PRICE       = 15,
   parameter int MAX_CREDIT  = 60,
   parameter int CREDIT_W    = 7,
   parameter int TIMEOUT_CYC = 1000,
   parameter int CHANGE_GAP  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          coin,
   input  logic                sel_valid,
   input  logic                cancel,
   input  logic                disp_ack,
   output logic                disp_req,
   output logic                change_pulse,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int GAP_W = $clog2(CHANGE_GAP + 1);
   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] MAX_C   = CREDIT_W'(MAX_CREDIT);
   localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(CHANGE_UNIT);
   localparam logic [CREDIT_W-1:0] ZERO_C  = {CREDIT_W{1'b0}};

   state_t              state;
   logic [CREDIT_W-1:0] coin_amt;
   logic                coin_present;
   logic                coin_ok;
   logic                sel_ok;
   logic                to_load;
   logic                to_expire;
   logic                gap_expire;
   logic                pay;

   assign coin_amt     = CREDIT_W'(coin_value(coin));
   assign coin_present = (coin != COIN_NONE);
   // Compare against the headroom rather than adding first, so nothing can wrap.
   assign coin_ok      = ((coin == COIN_5) || (coin == COIN_10)) && (credit <= (MAX_C - coin_amt));
   assign sel_ok       = sel_valid && (credit >= PRICE_C);

   // pay marks every edge that emits a change pulse and takes 5 off the credit.
   always_comb begin
      to_load = 1'b0;
      pay     = 1'b0;
      case (state)
         IDLE: begin
            to_load = coin_ok;
            pay     = 1'b0;
         end
         CREDIT: begin
            to_load = cancel | sel_valid | coin_ok;
            pay     = cancel | (~sel_valid & ~coin_ok & to_expire);
         end
         DISPENSE: begin
            to_load = 1'b0;
            pay     = disp_ack && (credit != ZERO_C);
         end
         CHANGE: begin
            to_load = 1'b0;
            pay     = (credit != ZERO_C) && gap_expire;
         end
         default: begin
            to_load = 1'b0;
            pay     = 1'b0;
         end
      endcase
   end

   vend_down_timer #(.W(TO_W)) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .load   (to_load),
      .value  (TO_W'(TIMEOUT_CYC)),
      .enable (state == CREDIT),
      .expire (to_expire)
   );

   vend_down_timer #(.W(GAP_W)) u_change_gap (
      .clk    (clk),
      .rst    (rst),
      .load   (pay),
      .value  (GAP_W'(CHANGE_GAP)),
      .enable (state == CHANGE),
      .expire (gap_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         credit       <= ZERO_C;
         disp_req     <= 1'b0;
         change_pulse <= 1'b0;
         coin_reject  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         change_pulse <= pay;
         case (state)
            IDLE: begin
               coin_reject <= coin_present & ~coin_ok;
               if (coin_ok) begin
                  credit <= credit + coin_amt;
                  state  <= CREDIT;
               end
            end
            CREDIT: begin
               if (cancel) begin
                  coin_reject <= coin_present;
                  credit      <= credit - UNIT_C;
                  busy        <= 1'b1;
                  state       <= CHANGE;
               end else if (sel_ok) begin
                  coin_reject <= coin_present;
                  credit      <= credit - PRICE_C;
                  disp_req    <= 1'b1;
                  busy        <= 1'b1;
                  state       <= DISPENSE;
               end else begin
                  coin_reject <= coin_present & ~coin_ok;
                  if (coin_ok) begin
                     credit <= credit + coin_amt;
                  end else if (pay) begin
                     credit <= credit - UNIT_C;
                     busy   <= 1'b1;
                     state  <= CHANGE;
                  end
               end
            end
            DISPENSE: begin
               coin_reject <= coin_present;
               if (disp_ack) begin
                  disp_req <= 1'b0;
                  if (pay) begin
                     credit <= credit - UNIT_C;
                     state  <= CHANGE;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            CHANGE: begin
               coin_reject <= coin_present;
               if (credit == ZERO_C) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (pay) begin
                  credit <= credit - UNIT_C;
               end
            end
            default: begin
               state       <= IDLE;
               disp_req    <= 1'b0;
               coin_reject <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_txn_controller.sv
// Self-checking bench: vector table plus hand-written timeout sequences; expected
// outputs are queued when inputs are driven and compared after the clock edge.
module tb_vend_txn_controller;

   localparam int PRICE       = 15;
   localparam int MAX_CREDIT  = 60;
   localparam int CREDIT_W    = 7;
   localparam int TIMEOUT_CYC = 1000;
   localparam int CHANGE_GAP  = 4;

   logic                clk;
   logic                rst;
   logic [1:0]          coin;
   logic                sel_valid;
   logic                cancel;
   logic                disp_ack;
   logic                disp_req;
   logic                change_pulse;
   logic                coin_reject;
   logic [CREDIT_W-1:0] credit;
   logic                busy;

   typedef struct {
      logic       do_rst;
      logic [1:0] c;
      logic       s;
      logic       cn;
      logic       a;
      logic       d;
      logic       p;
      logic       rj;
      logic [6:0] cr;
      logic       b;
   } vec_t;

   vec_t        tbl[$];
   logic [10:0] exp_q[$];
   string       name_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   vend_txn_controller #(
      .PRICE       (PRICE),
      .MAX_CREDIT  (MAX_CREDIT),
      .CREDIT_W    (CREDIT_W),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .CHANGE_GAP  (CHANGE_GAP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .coin         (coin),
      .sel_valid    (sel_valid),
      .cancel       (cancel),
      .disp_ack     (disp_ack),
      .disp_req     (disp_req),
      .change_pulse (change_pulse),
      .coin_reject  (coin_reject),
      .credit       (credit),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [10:0] pk(input logic d, input logic p, input logic rj,
                                      input logic b, input logic [6:0] cr);
      pk = {d, p, rj, b, cr};
   endfunction

   task automatic add(input logic r, input logic [1:0] c, input logic s, input logic cn,
                      input logic a, input logic d, input logic p, input logic rj,
                      input int cr, input logic b);
      vec_t v;
      v.do_rst = r; v.c = c; v.s = s; v.cn = cn; v.a = a;
      v.d = d; v.p = p; v.rj = rj; v.cr = 7'(cr); v.b = b;
      tbl.push_back(v);
   endtask

   task automatic check_out();
      logic [10:0] got;
      logic [10:0] want;
      string       nm;
      got = {disp_req, change_pulse, coin_reject, busy, credit};
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got outputs %b, required a queued expectation", got);
      end else begin
         want = exp_q.pop_front();
         nm   = name_q.pop_front();
         if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got disp=%b pulse=%b rej=%b busy=%b credit=%0d, required disp=%b pulse=%b rej=%b busy=%b credit=%0d",
                     nm, got[10], got[9], got[8], got[7], got[6:0],
                     want[10], want[9], want[8], want[7], want[6:0]);
         end
      end
   endtask

   task automatic step(input logic r, input logic [1:0] c, input logic s, input logic cn,
                       input logic a, input logic [10:0] want, input string nm);
      @(negedge clk);
      rst = r; coin = c; sel_valid = s; cancel = cn; disp_ack = a;
      exp_q.push_back(want);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic idle(input logic [10:0] want, input string nm);
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, want, nm);
   endtask

   initial begin
      rst = 1'b1; coin = 2'b00; sel_valid = 1'b0; cancel = 1'b0; disp_ack = 1'b0;

      //   rst coin  sel cnl ack | disp pls rej credit busy
      add(1, 2'b00, 0, 0, 0,   0, 0, 0,  0, 0);  // 0 reset state
      add(0, 2'b01, 0, 0, 0,   0, 0, 0,  5, 0);  // 1
      add(0, 2'b01, 0, 0, 0,   0, 0, 0, 10, 0);  // 2
      add(0, 2'b01, 0, 0, 0,   0, 0, 0, 15, 0);  // 3
      add(0, 2'b00, 1, 0, 0,   1, 0, 0,  0, 1);  // 4 exact price
      add(0, 2'b00, 0, 0, 0,   1, 0, 0,  0, 1);  // 5
      add(0, 2'b00, 0, 0, 0,   1, 0, 0,  0, 1);  // 6
      add(0, 2'b00, 0, 0, 1,   0, 0, 0,  0, 0);  // 7 ack, no change owed
      add(0, 2'b00, 0, 0, 0,   0, 0, 0,  0, 0);  // 8
      add(0, 2'b00, 0, 0, 1,   0, 0, 0,  0, 0);  // 9 stray ack ignored
      add(0, 2'b10, 0, 0, 0,   0, 0, 0, 10, 0);  // 10
      add(0, 2'b10, 0, 0, 0,   0, 0, 0, 20, 0);  // 11
      add(0, 2'b00, 1, 0, 0,   1, 0, 0,  5, 1);  // 12
      add(0, 2'b00, 0, 0, 1,   0, 1, 0,  0, 1);  // 13 one change pulse
      add(0, 2'b00, 0, 0, 0,   0, 0, 0,  0, 0);  // 14 back to idle
      add(0, 2'b00, 0, 0, 0,   0, 0, 0,  0, 0);  // 15
      for (int k = 1; k <= 6; k++) add(0, 2'b10, 0, 0, 0, 0, 0, 0, 10 * k, 0);  // 16..21
      add(0, 2'b10, 0, 0, 0,   0, 0, 1, 60, 0);  // 22 over ceiling
      add(0, 2'b11, 0, 0, 0,   0, 0, 1, 60, 0);  // 23 invalid coin
      add(0, 2'b01, 0, 0, 0,   0, 0, 1, 60, 0);  // 24 5 would exceed too
      add(0, 2'b10, 0, 1, 0,   0, 1, 1, 55, 1);  // 25 cancel wins over coin
      add(0, 2'b00, 0, 0, 0,   0, 0, 0, 55, 1);  // 26
      add(0, 2'b01, 0, 0, 0,   0, 0, 1, 55, 1);  // 27 coin during change
      add(0, 2'b00, 0, 0, 0,   0, 0, 0, 55, 1);  // 28
      add(0, 2'b00, 0, 0, 0,   0, 1, 0, 50, 1);  // 29 second pulse, gap 4
      add(1, 2'b00, 0, 0, 0,   0, 0, 0,  0, 0);  // 30 reset mid-change
      add(0, 2'b11, 0, 0, 0,   0, 0, 1,  0, 0);  // 31 bad coin in idle
      add(0, 2'b10, 1, 1, 0,   0, 0, 0, 10, 0);  // 32 sel/cancel ignored in idle
      add(0, 2'b00, 1, 0, 0,   0, 0, 0, 10, 0);  // 33 insufficient credit
      add(0, 2'b01, 1, 0, 0,   0, 0, 0, 15, 0);  // 34 coin still accepted
      add(0, 2'b00, 1, 0, 0,   1, 0, 0,  0, 1);  // 35
      add(0, 2'b10, 0, 1, 0,   1, 0, 1,  0, 1);  // 36 cancel ignored, coin rejected
      add(1, 2'b00, 0, 0, 0,   0, 0, 0,  0, 0);  // 37 reset mid-dispense
      add(0, 2'b00, 0, 0, 1,   0, 0, 0,  0, 0);  // 38 late ack no effect
      add(0, 2'b00, 0, 0, 0,   0, 0, 0,  0, 0);  // 39
      add(0, 2'b10, 0, 0, 0,   0, 0, 0, 10, 0);  // 40
      add(0, 2'b00, 0, 1, 0,   0, 1, 0,  5, 1);  // 41
      add(0, 2'b00, 0, 0, 0,   0, 0, 0,  5, 1);  // 42
      add(0, 2'b00, 1, 0, 0,   0, 0, 0,  5, 1);  // 43 sel ignored in change
      add(0, 2'b00, 0, 0, 0,   0, 0, 0,  5, 1);  // 44
      add(0, 2'b00, 0, 0, 0,   0, 1, 0,  0, 1);  // 45
      add(0, 2'b00, 0, 0, 0,   0, 0, 0,  0, 0);  // 46
      add(0, 2'b00, 0, 0, 0,   0, 0, 0,  0, 0);  // 47
      add(0, 2'b10, 0, 0, 0,   0, 0, 0, 10, 0);  // 48
      add(0, 2'b01, 0, 0, 0,   0, 0, 0, 15, 0);  // 49
      add(0, 2'b10, 1, 0, 0,   1, 0, 1,  0, 1);  // 50 select wins over coin
      add(0, 2'b00, 0, 0, 1,   0, 0, 0,  0, 0);  // 51
      add(0, 2'b00, 0, 0, 0,   0, 0, 0,  0, 0);  // 52

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].do_rst, tbl[i].c, tbl[i].s, tbl[i].cn, tbl[i].a,
              pk(tbl[i].d, tbl[i].p, tbl[i].rj, tbl[i].b, tbl[i].cr),
              $sformatf("vec%0d", i));
      end

      // Inactivity refund: exactly TIMEOUT_CYC quiet cycles after the coin.
      step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 7'd5), "to_coin");
      for (int i = 1; i < TIMEOUT_CYC; i++) idle(pk(0, 0, 0, 0, 7'd5), "to_wait");
      idle(pk(0, 1, 0, 1, 7'd0), "to_refund");
      idle(pk(0, 0, 0, 0, 7'd0), "to_idle");

      // A coin one cycle before expiry restarts the full timeout.
      step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 7'd5), "rl_coin");
      for (int i = 1; i < TIMEOUT_CYC - 1; i++) idle(pk(0, 0, 0, 0, 7'd5), "rl_wait1");
      step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 7'd10), "rl_reload");
      for (int i = 1; i < TIMEOUT_CYC; i++) idle(pk(0, 0, 0, 0, 7'd10), "rl_wait2");
      idle(pk(0, 1, 0, 1, 7'd5), "rl_pulse1");
      for (int i = 1; i < CHANGE_GAP; i++) idle(pk(0, 0, 0, 1, 7'd5), "rl_gap");
      idle(pk(0, 1, 0, 1, 7'd0), "rl_pulse2");
      idle(pk(0, 0, 0, 0, 7'd0), "rl_idle");

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
